// File: rtl/mips_cache_pkg.sv
// Shared types and constants for the MIPS data cache memory-side logic.
// The arbiter state encoding is fixed so checkers can decode it directly.
package mips_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } arb_state_e;

  localparam int          DEFAULT_LINE_WORDS = 4;
  localparam logic [3:0]  AVM_BE_ALL         = 4'hF;

endpackage

// File: rtl/mips_cache_mem_arbiter.sv
// Owns the single Avalon master port: buffered writes pass straight through,
// and a read miss drains the write buffer before a sequential line fill.
//
// Handshake: a request on either side is held stable while its waitrequest is
// high; it transfers in the cycle where request=1 and waitrequest=0.
module mips_cache_mem_arbiter
  import mips_cache_pkg::*;
#(
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int IDX_BITS   = $clog2(LINE_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fill_req,
  input  logic [31:0]         fill_addr,
  output logic                fill_word_valid,
  output logic [IDX_BITS-1:0] fill_word_idx,
  output logic [31:0]         fill_word_data,
  output logic                fill_done,
  output logic                busy,
  input  logic [31:0]         wb_write_addr,
  input  logic [31:0]         wb_write_data,
  input  logic [3:0]          wb_byteenable,
  input  logic                wb_writeenable,
  input  logic                wb_empty,
  output logic                wb_active,
  output logic                wb_waitrequest,
  output logic [31:0]         avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [31:0]         avm_writedata,
  output logic [3:0]          avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [31:0]         avm_readdata
);

  localparam logic [31:0]         LINE_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(LINE_WORDS - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [31:0]         base_q, base_d;
  logic                wb_drained;
  logic                word_accept;

  // The fill may only start once nothing is queued and nothing is in flight,
  // so every buffered write reaches memory before the miss read (RAW order).
  assign wb_drained  = wb_empty && !wb_writeenable;
  assign word_accept = (state_q == FILL) && !avm_waitrequest;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    base_d          = base_q;
    wb_active       = 1'b1;
    wb_waitrequest  = avm_waitrequest;
    avm_read        = 1'b0;
    avm_write       = wb_writeenable;
    avm_address     = wb_write_addr;
    avm_writedata   = wb_write_data;
    avm_byteenable  = wb_byteenable;
    fill_word_valid = 1'b0;
    fill_done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fill_req) begin
          base_d  = fill_addr & ~LINE_MASK;
          idx_d   = '0;
          state_d = wb_drained ? FILL : DRAIN;
        end
      end
      DRAIN: begin
        if (wb_drained) state_d = FILL;
      end
      FILL: begin
        wb_active      = 1'b0;
        wb_waitrequest = 1'b1;
        avm_write      = 1'b0;
        avm_byteenable = AVM_BE_ALL;
        avm_read       = 1'b1;
        avm_address    = base_q + {{(30 - IDX_BITS){1'b0}}, idx_q, 2'b00};
        if (word_accept) begin
          fill_word_valid = 1'b1;
          idx_d           = idx_q + IDX_BITS'(1);
          if (idx_q == LAST_IDX) begin
            fill_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_word_idx  = idx_q;
  assign fill_word_data = avm_readdata;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mips_cache_mem_arbiter.sv
// Self-checking bench for mips_cache_mem_arbiter: Avalon memory and write
// buffer models, a transaction scoreboard, directed cases, then random traffic.
`timescale 1ns/1ps
module tb_mips_cache_mem_arbiter;
  localparam int LW = 4;
  localparam int IB = $clog2(LW);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          fill_req;
  logic [31:0]   fill_addr;
  logic          fill_word_valid;
  logic [IB-1:0] fill_word_idx;
  logic [31:0]   fill_word_data;
  logic          fill_done;
  logic          busy;
  logic [31:0]   wb_write_addr, wb_write_data;
  logic [3:0]    wb_byteenable;
  logic          wb_writeenable, wb_empty, wb_active, wb_waitrequest;
  logic [31:0]   avm_address, avm_writedata, avm_readdata;
  logic          avm_read, avm_write, avm_waitrequest;
  logic [3:0]    avm_byteenable;

  mips_cache_mem_arbiter #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_word_valid(fill_word_valid), .fill_word_idx(fill_word_idx),
    .fill_word_data(fill_word_data), .fill_done(fill_done), .busy(busy),
    .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
    .wb_byteenable(wb_byteenable), .wb_writeenable(wb_writeenable),
    .wb_empty(wb_empty), .wb_active(wb_active), .wb_waitrequest(wb_waitrequest),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];                 // expected fill read addresses, in order
  wr_t         wq[$];                    // write buffer contents
  logic [31:0] mem [logic [31:0]];       // memory behind the Avalon port
  int          req_cyc = 0, first_rd_cyc = 0, done_cyc = 0;
  int          wr_push_cnt = 0, wr_done_cnt = 0, raw_need = 0;
  bit          fill_active = 0, fill_done_seen = 0, first_rd_pending = 0;
  int          stall_cnt = 0, wait_pct = 0, wr_pct = 0;
  bit          mon_en = 0;
  logic [31:0] ea;
  wr_t         mw;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t w;
    w.addr = a; w.data = d; w.be = be;
    wq.push_back(w);
    wr_push_cnt++;
  endtask

  // Write buffer and Avalon slave models, driven just after each edge.
  always @(posedge clk) begin
    #1;
    if (wr_pct != 0 && $urandom_range(99) < wr_pct)
      push_wr(32'h8000 + 32'($urandom_range(63)) * 4, $urandom, 4'($urandom_range(15, 1)));
    wb_writeenable = (wq.size() != 0);
    wb_empty       = (wq.size() == 0);
    if (wq.size() != 0) begin
      wb_write_addr = wq[0].addr;
      wb_write_data = wq[0].data;
      wb_byteenable = wq[0].be;
    end else begin
      wb_write_addr = '0;
      wb_write_data = '0;
      wb_byteenable = '0;
    end
    if (stall_cnt > 0) begin
      avm_waitrequest = 1'b1;
      stall_cnt--;
    end else begin
      avm_waitrequest = ($urandom_range(99) < wait_pct);
    end
    #1 avm_readdata = mem_rd(avm_address);
  end

  task automatic start_fill(input logic [31:0] a);
    logic [31:0] base;
    fill_addr        = a;
    fill_req         = 1'b1;
    req_cyc          = cyc;
    raw_need         = wr_push_cnt;
    fill_active      = 1;
    fill_done_seen   = 0;
    first_rd_pending = 1;
    base = a & ~32'(LW * 4 - 1);
    for (int k = 0; k < LW; k++) exp_q.push_back(base + 32'(k * 4));
  endtask

  task automatic do_fill(input logic [31:0] a);
    int n;
    @(posedge clk); #3;
    start_fill(a);
    n = 0;
    while (!fill_done_seen && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1 fill_req = 1'b0;
    check("fill_timeout", fill_done_seen, 1);
    check("fill_words_left", exp_q.size(), 0);
    exp_q.delete();
    fill_active = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("busy", busy, fill_active && (cyc > req_cyc));
      if (avm_read) begin
        if (first_rd_pending) begin
          first_rd_cyc     = cyc;
          first_rd_pending = 0;
        end
        check("rw_excl", avm_write, 0);
        check("wb_active_fill", wb_active, 0);
        check("wb_stall_fill", wb_waitrequest, 1);
        check("be_fill", avm_byteenable, 4'hF);
        if (exp_q.size() == 0) begin
          check("unexp_read", 1, 0);
        end else begin
          ea = exp_q[0];
          check("rd_addr", avm_address, ea);
          check("raw_order", wr_done_cnt >= raw_need, 1);
          check("word_valid", fill_word_valid, !avm_waitrequest);
          if (!avm_waitrequest) begin
            check("word_idx", fill_word_idx, ea[IB+1:2]);
            check("word_data", fill_word_data, mem_rd(ea));
            check("fill_done", fill_done, exp_q.size() == 1);
            if (exp_q.size() == 1) begin
              fill_done_seen = 1;
              fill_active    = 0;
              done_cyc       = cyc;
            end
            void'(exp_q.pop_front());
          end else begin
            check("no_done_stall", fill_done, 0);
          end
        end
      end else begin
        check("no_word", fill_word_valid, 0);
        check("no_done", fill_done, 0);
        check("wb_active", wb_active, 1);
        check("wr_follow", avm_write, wb_writeenable);
        check("wb_wait_mirror", wb_waitrequest, avm_waitrequest);
        if (avm_write) begin
          if (wq.size() == 0) begin
            check("unexp_write", 1, 0);
          end else begin
            mw = wq[0];
            check("wr_addr", avm_address, mw.addr);
            check("wr_data", avm_writedata, mw.data);
            check("wr_be", avm_byteenable, mw.be);
            if (!avm_waitrequest) begin
              mem[mw.addr] = merge(mem_rd(mw.addr), mw.data, mw.be);
              void'(wq.pop_front());
              wr_done_cnt++;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1; fill_req = 1'b0; fill_addr = '0;
    wb_write_addr = '0; wb_write_data = '0; wb_byteenable = '0;
    wb_writeenable = 1'b0; wb_empty = 1'b1;
    avm_waitrequest = 1'b0; avm_readdata = '0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_read", avm_read, 0);
    check("rst_done", fill_done, 0);
    check("rst_busy", busy, 0);
    check("rst_wb_active", wb_active, 1);
    check("rst_write", avm_write, 0);
    check("rst_valid", fill_word_valid, 0);
    mon_en = 1;

    // Write pass-through with two stall cycles.
    push_wr(32'h1000, 32'hDEADBEEF, 4'hF);
    stall_cnt = 2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("pt_write", avm_write, 1);
      check("pt_addr", avm_address, 32'h1000);
      check("pt_data", avm_writedata, 32'hDEADBEEF);
      check("pt_wb_wait", wb_waitrequest, k < 2);
    end
    @(negedge clk);
    check("pt_write_end", avm_write, 0);
    check("pt_mem", mem_rd(32'h1000), 32'hDEADBEEF);

    // Minimum-latency fill, empty buffer, unaligned miss address.
    do_fill(32'h2004);
    check("lat_first", first_rd_cyc, req_cyc + 1);
    check("lat_done", done_cyc, req_cyc + LW);

    // Fill with two writes pending: writes drain first, into the same line.
    @(negedge clk);
    push_wr(32'h3000, 32'h11112222, 4'hF);
    push_wr(32'h3004, 32'h33334444, 4'h3);
    do_fill(32'h3008);
    check("drain_delay", first_rd_cyc > req_cyc + 1, 1);
    check("drain_mem0", mem_rd(32'h3000), 32'h11112222);
    check("drain_cnt", wr_done_cnt, wr_push_cnt);

    // Three-cycle stall at word 2.
    fork
      do_fill(32'h2000);
      begin
        n = 0;
        while (exp_q.size() != LW - 2 && n < 50) begin
          @(posedge clk);
          n++;
        end
        check("stall_arm", exp_q.size(), LW - 2);
        stall_cnt = 3;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_addr", avm_address, 32'h2008);
          check("stall_valid", fill_word_valid, 0);
        end
      end
    join

    // Reset after word 1 of a fill is accepted.
    @(posedge clk); #3;
    start_fill(32'h5000);
    n = 0;
    while (exp_q.size() > LW - 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 rst = 1'b1; fill_req = 1'b0;
    @(posedge clk);
    #1 exp_q.delete(); fill_active = 0; first_rd_pending = 0; rst = 1'b0;
    @(negedge clk);
    check("mid_rst_read", avm_read, 0);
    check("mid_rst_wb_active", wb_active, 1);
    check("mid_rst_done", fill_done, 0);
    check("mid_rst_busy", busy, 0);
    do_fill(32'h4000);
    check("post_rst_lat", first_rd_cyc, req_cyc + 1);

    // Random traffic: overlapping writes and fills with random wait states.
    wait_pct = 25;
    wr_pct   = 30;
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(4)) @(posedge clk);
      do_fill(32'h8000 + 32'($urandom_range(255)));
    end
    wr_pct = 0;
    n = 0;
    while (wq.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("final_drain", wq.size(), 0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
    $fatal(1);
  end

endmodule
